// File: rtl/multisim_server_apb_manager.sv
// Server-side APB manager for the multisim APB channel.
// Accepts one APB request at a time from a vld/rdy stream, runs it on an APB4
// subordinate, and returns rdata/slverr/timeout on a vld/rdy response stream.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_req_vld/o_req_rdy              request handshake
//   i_req_addr/write/wdata/strb      request payload
//   o_resp_vld/i_resp_rdy            response handshake
//   o_resp_rdata/slverr/timeout      response payload
//   o_apb_m_*                        APB manager outputs (paddr, psel, penable, pwrite, pwdata, pstrb)
//   i_apb_m_pready/prdata/pslverr    APB subordinate returns
module multisim_server_apb_manager #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req_vld,
    output logic                    o_req_rdy,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic                    i_req_write,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_strb,
    output logic                    o_resp_vld,
    input  logic                    i_resp_rdy,
    output logic [DATA_WIDTH-1:0]   o_resp_rdata,
    output logic                    o_resp_slverr,
    output logic                    o_resp_timeout,
    output logic [ADDR_WIDTH-1:0]   o_apb_m_paddr,
    output logic                    o_apb_m_psel,
    output logic                    o_apb_m_penable,
    output logic                    o_apb_m_pwrite,
    output logic [DATA_WIDTH-1:0]   o_apb_m_pwdata,
    output logic [DATA_WIDTH/8-1:0] o_apb_m_pstrb,
    input  logic                    i_apb_m_pready,
    input  logic [DATA_WIDTH-1:0]   i_apb_m_prdata,
    input  logic                    i_apb_m_pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    // Keep the counter at least one bit wide even when the timeout is disabled.
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value seen during the last permitted ACCESS cycle.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                  state_q,   state_d;
    logic [CNT_WIDTH-1:0]    cnt_q,     cnt_d;
    logic                    req_rdy_q, req_rdy_d;
    logic                    psel_q,    psel_d;
    logic                    penable_q, penable_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
    logic                    pwrite_q,  pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q,   pstrb_d;
    logic                    resp_vld_q, resp_vld_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic                    slverr_q,  slverr_d;
    logic                    timeout_q, timeout_d;
    logic                    timeout_hit;

    // Next-state, payload capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rdata_d     = rdata_q;
        slverr_d    = slverr_q;
        timeout_d   = timeout_q;
        timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (i_req_vld) begin
                    state_d  = ST_SETUP;
                    paddr_d  = i_req_addr;
                    pwrite_d = i_req_write;
                    pwdata_d = i_req_wdata;
                    pstrb_d  = i_req_write ? i_req_strb : '0;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (i_apb_m_pready || timeout_hit) begin
                    state_d   = ST_RESP;
                    rdata_d   = (i_apb_m_pready && !pwrite_q) ? i_apb_m_prdata : '0;
                    slverr_d  = i_apb_m_pready ? i_apb_m_pslverr : 1'b1;
                    timeout_d = !i_apb_m_pready;
                    paddr_d   = '0;
                    pwrite_d  = 1'b0;
                    pwdata_d  = '0;
                    pstrb_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                if (i_resp_rdy) begin
                    state_d   = ST_IDLE;
                    rdata_d   = '0;
                    slverr_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_rdy_d  = (state_d == ST_IDLE);
        psel_d     = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d  = (state_d == ST_ACCESS);
        resp_vld_d = (state_d == ST_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_rdy_q  <= 1'b1;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            resp_vld_q <= 1'b0;
            rdata_q    <= '0;
            slverr_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_rdy_q  <= req_rdy_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            resp_vld_q <= resp_vld_d;
            rdata_q    <= rdata_d;
            slverr_q   <= slverr_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_req_rdy       = req_rdy_q;
    assign o_resp_vld      = resp_vld_q;
    assign o_resp_rdata    = rdata_q;
    assign o_resp_slverr   = slverr_q;
    assign o_resp_timeout  = timeout_q;
    assign o_apb_m_paddr   = paddr_q;
    assign o_apb_m_psel    = psel_q;
    assign o_apb_m_penable = penable_q;
    assign o_apb_m_pwrite  = pwrite_q;
    assign o_apb_m_pwdata  = pwdata_q;
    assign o_apb_m_pstrb   = pstrb_q;

endmodule

// File: tb/tb_multisim_server_apb_manager.sv
// Bench for multisim_server_apb_manager: request driver, APB subordinate with
// its own memory, reference model feeding a response scoreboard.
module tb_multisim_server_apb_manager;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst_n;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic [31:0] i_req_addr;
    logic        i_req_write;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_strb;
    logic        o_resp_vld;
    logic        i_resp_rdy;
    logic [31:0] o_resp_rdata;
    logic        o_resp_slverr;
    logic        o_resp_timeout;
    logic [31:0] o_apb_m_paddr;
    logic        o_apb_m_psel;
    logic        o_apb_m_penable;
    logic        o_apb_m_pwrite;
    logic [31:0] o_apb_m_pwdata;
    logic [3:0]  o_apb_m_pstrb;
    logic        i_apb_m_pready;
    logic [31:0] i_apb_m_prdata;
    logic        i_apb_m_pslverr;

    multisim_server_apb_manager #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
        .i_req_addr(i_req_addr), .i_req_write(i_req_write),
        .i_req_wdata(i_req_wdata), .i_req_strb(i_req_strb),
        .o_resp_vld(o_resp_vld), .i_resp_rdy(i_resp_rdy),
        .o_resp_rdata(o_resp_rdata), .o_resp_slverr(o_resp_slverr),
        .o_resp_timeout(o_resp_timeout),
        .o_apb_m_paddr(o_apb_m_paddr), .o_apb_m_psel(o_apb_m_psel),
        .o_apb_m_penable(o_apb_m_penable), .o_apb_m_pwrite(o_apb_m_pwrite),
        .o_apb_m_pwdata(o_apb_m_pwdata), .o_apb_m_pstrb(o_apb_m_pstrb),
        .i_apb_m_pready(i_apb_m_pready), .i_apb_m_prdata(i_apb_m_prdata),
        .i_apb_m_pslverr(i_apb_m_pslverr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        err;
        int          acc_cycles;
    } cfg_t;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
        int          acc;
        int          lat;
        int          rdy_delay;
    } exp_t;

    cfg_t        slv_q[$];
    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = -1;
    bit chk_spacing = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
    endfunction

    // Drive one request, push model expectations at the accepting edge.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input int waits, input logic err,
                         input int rdly, input bit keep_vld);
        cfg_t c;
        exp_t e;
        bit   done;
        int   n;
        logic [31:0] m;
        i_req_vld   = 1'b1;
        i_req_addr  = addr;
        i_req_write = wr;
        i_req_wdata = wd;
        i_req_strb  = st;
        done = 0;
        n = 0;
        while (!done && n < 200) begin
            if (o_req_rdy) done = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL req_accept: request not accepted within %0d cycles", n);
            i_req_vld = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (chk_spacing && last_acc >= 0) chk("accept_spacing", 64'(e.acc - last_acc), 64'd4);
        last_acc = e.acc;
        c.acc_cycles = (waits + 1 < int'(TO)) ? waits + 1 : int'(TO);
        e.lat        = 2 + c.acc_cycles;
        e.rdy_delay  = rdly;
        if (waits + 1 > int'(TO)) begin
            e.rdata = '0; e.slverr = 1'b1; e.timeout = 1'b1;
        end else begin
            e.slverr = err; e.timeout = 1'b0;
            if (wr) begin
                e.rdata = '0;
                if (!err) begin
                    m = ref_rd(addr);
                    for (int i = 0; i < 4; i++) if (st[i]) m[8*i +: 8] = wd[8*i +: 8];
                    ref_mem[addr] = m;
                end
            end else begin
                e.rdata = ref_rd(addr);
            end
        end
        c.addr = addr; c.write = wr; c.wdata = wd; c.strb = wr ? st : 4'h0;
        c.waits = waits; c.err = err;
        slv_q.push_back(c);
        exp_q.push_back(e);
        @(negedge clk);
        if (!keep_vld) i_req_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !o_req_rdy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL idle_wait: pending=%0d req_rdy=%0b required 0 pending and req_rdy=1",
                     exp_q.size(), o_req_rdy);
        end
    endtask

    // Response monitor / scoreboard.
    exp_t me;
    bit   m_seen = 0;
    int   m_hold = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_seen = 0;
            i_resp_rdy = 1'b0;
        end else if (o_resp_vld) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: rdata=0x%0h with no pending request", o_resp_rdata);
                i_resp_rdy = 1'b1;
            end else begin
                me = exp_q[0];
                if (!m_seen) begin
                    m_seen = 1;
                    m_hold = 0;
                    chk("resp_latency", 64'(cyc + 1 - me.acc), 64'(me.lat));
                end
                i_resp_rdy = (m_hold >= me.rdy_delay);
                m_hold++;
                chk("resp_rdata",   64'(o_resp_rdata),   64'(me.rdata));
                chk("resp_slverr",  64'(o_resp_slverr),  64'(me.slverr));
                chk("resp_timeout", 64'(o_resp_timeout), 64'(me.timeout));
                chk("req_rdy_during_resp", 64'(o_req_rdy), 64'd0);
                if (i_resp_rdy) begin
                    void'(exp_q.pop_front());
                    m_seen = 0;
                end
            end
        end else begin
            i_resp_rdy = 1'b0;
        end
    end

    // APB subordinate: waits/err come from the per-transaction config.
    cfg_t s_cur;
    bit   s_active = 0;
    int   s_en = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            slv_q.delete();
            s_active = 0;
            i_apb_m_pready  = 1'b0;
            i_apb_m_pslverr = 1'b0;
            i_apb_m_prdata  = '0;
        end else if (o_apb_m_psel && !o_apb_m_penable) begin
            if (slv_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_setup: paddr=0x%0h", o_apb_m_paddr);
            end else begin
                s_cur = slv_q.pop_front();
                s_active = 1;
                s_en = 0;
                chk("setup_paddr",  64'(o_apb_m_paddr),  64'(s_cur.addr));
                chk("setup_pwrite", 64'(o_apb_m_pwrite), 64'(s_cur.write));
                chk("setup_pstrb",  64'(o_apb_m_pstrb),  64'(s_cur.strb));
                if (s_cur.write) chk("setup_pwdata", 64'(o_apb_m_pwdata), 64'(s_cur.wdata));
            end
            i_apb_m_pready  = 1'b0;
            i_apb_m_pslverr = 1'b0;
            i_apb_m_prdata  = $urandom;
        end else if (o_apb_m_psel && o_apb_m_penable) begin
            chk("access_paddr", 64'(o_apb_m_paddr), 64'(s_cur.addr));
            chk("access_pstrb", 64'(o_apb_m_pstrb), 64'(s_cur.strb));
            i_apb_m_pready  = (s_en == s_cur.waits);
            i_apb_m_pslverr = i_apb_m_pready ? s_cur.err : 1'b1;
            i_apb_m_prdata  = (i_apb_m_pready && !s_cur.write) ? slv_rd(s_cur.addr) : $urandom;
            s_en++;
        end else begin
            if (s_active) begin
                chk("access_cycles", 64'(s_en), 64'(s_cur.acc_cycles));
                s_active = 0;
            end
            i_apb_m_pready  = 1'b0;
            i_apb_m_pslverr = 1'b0;
            i_apb_m_prdata  = $urandom;
        end
    end

    // Subordinate memory update on a completed, error-free write.
    initial forever begin
        @(posedge clk);
        if (rst_n && o_apb_m_psel && o_apb_m_penable && i_apb_m_pready &&
            o_apb_m_pwrite && !i_apb_m_pslverr) begin
            logic [31:0] m;
            m = slv_rd(o_apb_m_paddr);
            for (int i = 0; i < 4; i++)
                if (o_apb_m_pstrb[i]) m[8*i +: 8] = o_apb_m_pwdata[8*i +: 8];
            slv_mem[o_apb_m_paddr] = m;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        i_req_vld = 1'b0; i_req_addr = '0; i_req_write = 1'b0;
        i_req_wdata = '0; i_req_strb = '0;
        i_resp_rdy = 1'b0;
        i_apb_m_pready = 1'b0; i_apb_m_prdata = '0; i_apb_m_pslverr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy",  64'(o_req_rdy),       64'd1);
        chk("rst_psel",     64'(o_apb_m_psel),    64'd0);
        chk("rst_penable",  64'(o_apb_m_penable), 64'd0);
        chk("rst_resp_vld", 64'(o_resp_vld),      64'd0);
        chk("rst_paddr",    64'(o_apb_m_paddr),   64'd0);
        chk("rst_rdata",    64'(o_resp_rdata),    64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write.
        issue(32'h1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0, 0);
        wait_idle();
        // Read with three wait states.
        ref_mem[32'h2004] = 32'hCAFE_F00D;
        slv_mem[32'h2004] = 32'hCAFE_F00D;
        issue(32'h2004, 1'b0, 32'h1111_2222, 4'hF, 3, 1'b0, 0, 0);
        wait_idle();
        // Error read with response back-pressure.
        issue(32'h1000, 1'b0, 32'h0, 4'hF, 0, 1'b1, 5, 0);
        wait_idle();
        // Hung subordinate, then pready on the last permitted cycle.
        issue(32'h3000, 1'b0, 32'h0, 4'h0, 50, 1'b0, 0, 0);
        wait_idle();
        issue(32'h3000, 1'b0, 32'h0, 4'h0, int'(TO) - 1, 1'b0, 0, 0);
        wait_idle();

        // Back-to-back random traffic.
        chk_spacing = 1;
        last_acc = -1;
        for (int i = 0; i < 10; i++)
            issue(32'h4000 + 32'(4 * $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom, 4'($urandom_range(0, 15)), 0, 1'b0, 0, 1);
        i_req_vld = 1'b0;
        chk_spacing = 0;
        wait_idle();

        // Reset in the middle of ACCESS.
        issue(32'h1000, 1'b0, 32'h0, 4'h0, 5, 1'b0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_psel",     64'(o_apb_m_psel),    64'd0);
        chk("midrst_penable",  64'(o_apb_m_penable), 64'd0);
        chk("midrst_resp_vld", 64'(o_resp_vld),      64'd0);
        chk("midrst_req_rdy",  64'(o_req_rdy),       64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_req_rdy", 64'(o_req_rdy), 64'd1);
        issue(32'h1004, 1'b1, 32'hA5A5_5A5A, 4'h5, 1, 1'b0, 0, 0);
        wait_idle();
        issue(32'h1004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 0, 0);
        wait_idle();

        // Random mix including errors, timeouts and back-pressure.
        for (int i = 0; i < 30; i++)
            issue(32'h4000 + 32'(4 * $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 9)),
                  1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
